// File: rtl/spi_master_controller.sv
// SPI transfer sequencer: loads a byte into an external sender, runs eight SCLK
// periods, then captures the receiver's parallel byte and reports completion.
//
// state   | meaning
// IDLE    | CS_N high, waiting for START
// LOAD    | one cycle, WRITE strobes TX_DATA into the sender
// SHIFT   | 16 half-periods of SCLK, TE/RE enabled
// CAPTURE | one cycle, READ strobe, RX_IN latched into RX_DATA
// FINISH  | one cycle, DONE pulse, transfer count bumped
module spi_master_controller #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] TX_IN,
  input  logic [7:0] RX_IN,
  output logic       SCLK,
  output logic       CS_N,
  output logic       WRITE,
  output logic       TE,
  output logic       RE,
  output logic       READ,
  output logic [7:0] TX_DATA,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORTED,
  output logic [7:0] XFER_CNT
);

  localparam logic [7:0] HP_RELOAD = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t     state_q, state_d;
  logic       sclk_q, sclk_d;
  logic [7:0] hp_cnt_q, hp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] xfer_cnt_q, xfer_cnt_d;
  logic       aborted_q, aborted_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= S_IDLE;
      sclk_q     <= 1'b0;
      hp_cnt_q   <= 8'h00;
      bit_cnt_q  <= 3'd0;
      tx_data_q  <= 8'h00;
      rx_data_q  <= 8'h00;
      xfer_cnt_q <= 8'h00;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      hp_cnt_q   <= hp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_data_q  <= tx_data_d;
      rx_data_q  <= rx_data_d;
      xfer_cnt_q <= xfer_cnt_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    hp_cnt_d   = hp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_data_d  = tx_data_q;
    rx_data_d  = rx_data_q;
    xfer_cnt_d = xfer_cnt_q;
    aborted_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          tx_data_d = TX_IN;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        sclk_d = 1'b0;
        if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          hp_cnt_d  = HP_RELOAD;
          bit_cnt_d = 3'd0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ABORT) begin
          aborted_d = 1'b1;
          sclk_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (hp_cnt_q == 8'h00) begin
          // Half-period expired: toggle SCLK; a falling edge closes one bit.
          hp_cnt_d = HP_RELOAD;
          sclk_d   = ~sclk_q;
          if (sclk_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_CAPTURE;
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q - 8'h01;
        end
      end
      S_CAPTURE: begin
        rx_data_d  = RX_IN;
        xfer_cnt_d = xfer_cnt_q + 8'h01;
        state_d    = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SCLK     = sclk_q;
  assign BUSY     = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CAPTURE);
  assign CS_N     = ~BUSY;
  assign WRITE    = (state_q == S_LOAD);
  assign TE       = (state_q == S_SHIFT);
  assign RE       = (state_q == S_SHIFT);
  assign READ     = (state_q == S_CAPTURE);
  assign DONE     = (state_q == S_FINISH);
  assign ABORTED  = aborted_q;
  assign TX_DATA  = tx_data_q;
  assign RX_DATA  = rx_data_q;
  assign XFER_CNT = xfer_cnt_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Bench for spi_master_controller: two instances (half-period 1 and 4) share
// stimulus; per-cycle strobes are compared against a cycle-offset timeline model.
module tb_spi_master_controller;

  // Output vector bit order: SCLK CS_N WRITE TE RE READ BUSY DONE ABORTED
  localparam logic [8:0] IDLE_V = 9'b0_1_0_0_0_0_0_0_0;

  logic       clk;
  logic       clr;
  logic       start;
  logic       abort_i;
  logic [7:0] tx_in;
  logic [7:0] rx_in;

  logic       sclk1, cs_n1, write1, te1, re1, read1, busy1, done1, aborted1;
  logic [7:0] tx_data1, rx_data1, xfer_cnt1;
  logic       sclk4, cs_n4, write4, te4, re4, read4, busy4, done4, aborted4;
  logic [7:0] tx_data4, rx_data4, xfer_cnt4;

  int checks;
  int errors;

  spi_master_controller #(.HALF_PERIOD(1)) u_dut1 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort_i),
    .TX_IN(tx_in), .RX_IN(rx_in),
    .SCLK(sclk1), .CS_N(cs_n1), .WRITE(write1), .TE(te1), .RE(re1), .READ(read1),
    .TX_DATA(tx_data1), .RX_DATA(rx_data1),
    .BUSY(busy1), .DONE(done1), .ABORTED(aborted1), .XFER_CNT(xfer_cnt1)
  );

  spi_master_controller #(.HALF_PERIOD(4)) u_dut4 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort_i),
    .TX_IN(tx_in), .RX_IN(rx_in),
    .SCLK(sclk4), .CS_N(cs_n4), .WRITE(write4), .TE(te4), .RE(re4), .READ(read4),
    .TX_DATA(tx_data4), .RX_DATA(rx_data4),
    .BUSY(busy4), .DONE(done4), .ABORTED(aborted4), .XFER_CNT(xfer_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobes r cycles after the cycle in which START was accepted
  // (r=1 is LOAD). abort_r is the cycle in which ABORT was held, -1 for none.
  function automatic logic [8:0] model_vec(input int h, input int r, input int abort_r);
    logic sclk_e;
    if (abort_r >= 1 && abort_r <= 1 + 16 * h && r > abort_r)
      return (r == abort_r + 1) ? 9'b0_1_0_0_0_0_0_0_1 : IDLE_V;
    if (r == 1) return 9'b0_0_1_0_0_0_1_0_0;
    if (r >= 2 && r <= 1 + 16 * h) begin
      sclk_e = (((r - 2) / h) % 2) == 1;
      return {sclk_e, 8'b0_0_1_1_0_1_0_0};
    end
    if (r == 2 + 16 * h) return 9'b0_0_0_0_0_1_1_0_0;
    if (r == 3 + 16 * h) return 9'b0_1_0_0_0_0_0_1_0;
    return IDLE_V;
  endfunction

  // START held from cycle 0 to cycle hold_last: a transfer begins every 4+16h cycles.
  function automatic logic [8:0] model_held(input int h, input int t, input int hold_last);
    int p;
    int s;
    p = 4 + 16 * h;
    s = (t / p) * p;
    if (s <= hold_last) return model_vec(h, t - s, -1);
    return IDLE_V;
  endfunction

  function automatic logic [7:0] tx_at(input int t);
    return 8'((t * 7 + 3) & 255);
  endfunction

  // Samples the current cycle's outputs, drives this cycle's inputs, advances one clock.
  task automatic cycle_io(input logic s, input logic a, input logic c,
                          input logic [7:0] tx, input logic [7:0] rx,
                          output logic [8:0] v1, output logic [8:0] v4,
                          output logic [23:0] d1, output logic [23:0] d4);
    v1 = {sclk1, cs_n1, write1, te1, re1, read1, busy1, done1, aborted1};
    v4 = {sclk4, cs_n4, write4, te4, re4, read4, busy4, done4, aborted4};
    d1 = {tx_data1, rx_data1, xfer_cnt1};
    d4 = {tx_data4, rx_data4, xfer_cnt4};
    start   = s;
    abort_i = a;
    clr     = c;
    tx_in   = tx;
    rx_in   = rx;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0]  v1, v4;
    logic [23:0] d1, d4;
    cycle_io(1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE, v1, v4, d1, d4);
    cycle_io(1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE, v1, v4, d1, d4);
    cycle_io(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, v1, v4, d1, d4);
    checks++;
    if (v1 !== IDLE_V) begin errors++; $display("FAIL reset_vec_h1 got=%b exp=%b", v1, IDLE_V); end
    checks++;
    if (v4 !== IDLE_V) begin errors++; $display("FAIL reset_vec_h4 got=%b exp=%b", v4, IDLE_V); end
    checks++;
    if (d1 !== 24'h0) begin errors++; $display("FAIL reset_data_h1 got=%h exp=000000", d1); end
    checks++;
    if (d4 !== 24'h0) begin errors++; $display("FAIL reset_data_h4 got=%h exp=000000", d4); end
  endtask

  task automatic test_basic();
    logic [8:0]  v1, v4, e1, e4;
    logic [23:0] d1, d4;
    int rises[$];
    logic prev4;
    cycle_io(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, v1, v4, d1, d4);
    prev4 = 1'b0;
    for (int t = 0; t <= 75; t++) begin
      cycle_io(t == 0, 1'b0, 1'b0, 8'hA5, 8'h3C, v1, v4, d1, d4);
      e1 = model_vec(1, t, -1);
      e4 = model_vec(4, t, -1);
      checks++;
      if (v1 !== e1) begin errors++; $display("FAIL basic_vec_h1 t=%0d got=%b exp=%b", t, v1, e1); end
      checks++;
      if (v4 !== e4) begin errors++; $display("FAIL basic_vec_h4 t=%0d got=%b exp=%b", t, v4, e4); end
      if (v4[8] === 1'b1 && prev4 === 1'b0) rises.push_back(t);
      prev4 = v4[8];
    end
    checks++;
    if (rises.size() != 8) begin
      errors++; $display("FAIL basic_sclk_rise_count got=%0d exp=8", rises.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rises[k] != 6 + 8 * k) begin
          errors++; $display("FAIL basic_sclk_rise k=%0d got=%0d exp=%0d", k, rises[k], 6 + 8 * k);
        end
      end
    end
    checks++;
    if (d1 !== 24'hA53C01) begin errors++; $display("FAIL basic_data_h1 got=%h exp=a53c01", d1); end
    checks++;
    if (d4 !== 24'hA53C01) begin errors++; $display("FAIL basic_data_h4 got=%h exp=a53c01", d4); end
  endtask

  task automatic test_random();
    logic [8:0]  v1, v4, e1, e4;
    logic [23:0] d1, d4, x1, x4;
    logic [7:0]  tx, tx2, rx, txv;
    int abort_r;
    int stray;
    logic ok1, ok4;
    for (int it = 0; it < 8; it++) begin
      tx  = 8'($urandom_range(0, 255));
      tx2 = tx ^ 8'($urandom_range(1, 255));
      rx  = 8'($urandom_range(0, 255));
      abort_r = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 80)) : -1;
      stray   = (abort_r < 0) ? int'($urandom_range(2, 17)) : -1;
      cycle_io(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, v1, v4, d1, d4);
      for (int t = 0; t <= 75; t++) begin
        txv = (t == stray) ? tx2 : tx;
        cycle_io((t == 0) || (t == stray), t == abort_r, 1'b0, txv, rx, v1, v4, d1, d4);
        e1 = model_vec(1, t, abort_r);
        e4 = model_vec(4, t, abort_r);
        checks++;
        if (v1 !== e1) begin errors++; $display("FAIL rand_vec_h1 it=%0d t=%0d abort=%0d got=%b exp=%b", it, t, abort_r, v1, e1); end
        checks++;
        if (v4 !== e4) begin errors++; $display("FAIL rand_vec_h4 it=%0d t=%0d abort=%0d got=%b exp=%b", it, t, abort_r, v4, e4); end
      end
      ok1 = !(abort_r >= 1 && abort_r <= 17);
      ok4 = !(abort_r >= 1 && abort_r <= 65);
      x1 = {tx, ok1 ? rx : 8'h00, ok1 ? 8'h01 : 8'h00};
      x4 = {tx, ok4 ? rx : 8'h00, ok4 ? 8'h01 : 8'h00};
      checks++;
      if (d1 !== x1) begin errors++; $display("FAIL rand_data_h1 it=%0d got=%h exp=%h", it, d1, x1); end
      checks++;
      if (d4 !== x4) begin errors++; $display("FAIL rand_data_h4 it=%0d got=%h exp=%h", it, d4, x4); end
    end
  endtask

  task automatic test_clr_mid();
    logic [8:0]  v1, v4, e1, e4;
    logic [23:0] d1, d4;
    cycle_io(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, v1, v4, d1, d4);
    for (int t = 0; t <= 115; t++) begin
      cycle_io((t == 0) || (t == 40), t == 30, t == 30, (t < 40) ? 8'h5A : 8'hC3, 8'h96,
               v1, v4, d1, d4);
      if (t <= 30) begin
        e1 = model_vec(1, t, -1);
        e4 = model_vec(4, t, -1);
      end else if (t < 40) begin
        e1 = IDLE_V;
        e4 = IDLE_V;
      end else begin
        e1 = model_vec(1, t - 40, -1);
        e4 = model_vec(4, t - 40, -1);
      end
      checks++;
      if (v1 !== e1) begin errors++; $display("FAIL clr_vec_h1 t=%0d got=%b exp=%b", t, v1, e1); end
      checks++;
      if (v4 !== e4) begin errors++; $display("FAIL clr_vec_h4 t=%0d got=%b exp=%b", t, v4, e4); end
      if (t == 31) begin
        checks++;
        if (d1 !== 24'h0) begin errors++; $display("FAIL clr_data_h1 got=%h exp=000000", d1); end
        checks++;
        if (d4 !== 24'h0) begin errors++; $display("FAIL clr_data_h4 got=%h exp=000000", d4); end
      end
    end
    checks++;
    if (d1 !== 24'hC39601) begin errors++; $display("FAIL clr_after_h1 got=%h exp=c39601", d1); end
    checks++;
    if (d4 !== 24'hC39601) begin errors++; $display("FAIL clr_after_h4 got=%h exp=c39601", d4); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  v1, v4, e1, e4;
    logic [23:0] d1, d4, x1, x4;
    int dones[$];
    cycle_io(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, v1, v4, d1, d4);
    for (int t = 0; t <= 90; t++) begin
      cycle_io(t <= 50, 1'b0, 1'b0, tx_at(t), 8'h71, v1, v4, d1, d4);
      e1 = model_held(1, t, 50);
      e4 = model_held(4, t, 50);
      checks++;
      if (v1 !== e1) begin errors++; $display("FAIL b2b_vec_h1 t=%0d got=%b exp=%b", t, v1, e1); end
      checks++;
      if (v4 !== e4) begin errors++; $display("FAIL b2b_vec_h4 t=%0d got=%b exp=%b", t, v4, e4); end
      if (v1[1] === 1'b1) dones.push_back(t);
    end
    checks++;
    if (dones.size() != 3) begin
      errors++; $display("FAIL b2b_done_count got=%0d exp=3", dones.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dones[k] != 19 + 20 * k) begin
          errors++; $display("FAIL b2b_done_cycle k=%0d got=%0d exp=%0d", k, dones[k], 19 + 20 * k);
        end
      end
    end
    x1 = {tx_at(40), 8'h71, 8'h03};
    x4 = {tx_at(0), 8'h71, 8'h01};
    checks++;
    if (d1 !== x1) begin errors++; $display("FAIL b2b_data_h1 got=%h exp=%h", d1, x1); end
    checks++;
    if (d4 !== x4) begin errors++; $display("FAIL b2b_data_h4 got=%h exp=%h", d4, x4); end
  endtask

  task automatic test_wrap();
    logic [8:0]  v1, v4, e1, e4;
    logic [23:0] d1, d4;
    logic [7:0]  tx, rx;
    tx = 8'($urandom_range(0, 255));
    rx = 8'($urandom_range(0, 255));
    cycle_io(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, v1, v4, d1, d4);
    for (int t = 0; t <= 5170; t++) begin
      cycle_io(t <= 5100, 1'b0, 1'b0, tx, rx, v1, v4, d1, d4);
      e1 = model_held(1, t, 5100);
      e4 = model_held(4, t, 5100);
      checks++;
      if (v1 !== e1) begin errors++; $display("FAIL wrap_vec_h1 t=%0d got=%b exp=%b", t, v1, e1); end
      checks++;
      if (v4 !== e4) begin errors++; $display("FAIL wrap_vec_h4 t=%0d got=%b exp=%b", t, v4, e4); end
      if (t == 5100) begin
        checks++;
        if (d1[7:0] !== 8'd255) begin errors++; $display("FAIL wrap_pre_h1 got=%0d exp=255", d1[7:0]); end
        checks++;
        if (d4[7:0] !== 8'd75) begin errors++; $display("FAIL wrap_pre_h4 got=%0d exp=75", d4[7:0]); end
      end
    end
    checks++;
    if (d1 !== {tx, rx, 8'd0}) begin errors++; $display("FAIL wrap_post_h1 got=%h exp=%h", d1, {tx, rx, 8'd0}); end
    checks++;
    if (d4 !== {tx, rx, 8'd76}) begin errors++; $display("FAIL wrap_post_h4 got=%h exp=%h", d4, {tx, rx, 8'd76}); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr     = 1'b1;
    start   = 1'b0;
    abort_i = 1'b0;
    tx_in   = 8'h00;
    rx_in   = 8'h00;
    test_reset();
    test_basic();
    test_random();
    test_clr_mid();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_controller.md
SPI_MASTER_CONTROLLER -- requirements
Module: spi_master_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 4, SHALL set the number of CLK cycles per SCLK half-period; legal range is 1..255.
REQ-002 CLK  input  1  system clock; all logic SHALL be updated on its rising edge.
REQ-003 CLR  input  1  reset; synchronous and active-high.
REQ-004 START  input  1  transfer request, sampled only in IDLE.
REQ-005 ABORT  input  1  cancels a transfer in LOAD or SHIFT.
REQ-006 TX_IN  input  8  byte to transmit, latched when START is accepted.
REQ-007 RX_IN  input  8  receiver parallel data bus, sampled in CAPTURE.
REQ-008 SCLK  output  1  serial clock to the sender and receiver CLK pins.
REQ-009 CS_N  output  1  slave select, active-low.
REQ-010 WRITE, TE, RE, READ  output  1 each  sender/receiver control strobes.
REQ-011 TX_DATA  output  8  parallel load value for the sender DATA bus.
REQ-012 RX_DATA  output  8  last received byte.
REQ-013 BUSY, DONE, ABORTED  output  1 each  status signals.
REQ-014 XFER_CNT  output  8  count of completed transfers.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD, SHIFT, CAPTURE, FINISH.
REQ-016 IDLE: outputs are CS_N=1, BUSY=0, and TE=RE=WRITE=READ=0; when START=1, the block SHALL latch TX_IN into TX_DATA and move to LOAD on the next edge.
REQ-017 LOAD (one cycle): outputs are CS_N=0, BUSY=1, WRITE=1; the next state SHALL be SHIFT.
REQ-018 SHIFT: outputs are CS_N=0, BUSY=1, TE=RE=1; SCLK SHALL enter low and toggle after every HALF_PERIOD cycles in SHIFT.
REQ-019 SHIFT SHALL last exactly 16*HALF_PERIOD cycles, producing 8 SCLK rising edges, with SCLK low on exit; the next state SHALL be CAPTURE.
REQ-020 CAPTURE (one cycle): outputs are READ=1, CS_N=0; RX_DATA SHALL be loaded from RX_IN at the end of the cycle; the next state SHALL be FINISH.
REQ-021 FINISH (one cycle): DONE=1 and CS_N=1; XFER_CNT SHALL increment with wrap 255->0; the next state SHALL be IDLE.
REQ-022 Latency: with START accepted at edge 0, LOAD SHALL be cycle 1, SHIFT cycles 2..1+16H, CAPTURE cycle 2+16H, and FINISH cycle 3+16H.
REQ-023 BUSY SHALL be 1 from LOAD through CAPTURE inclusive, and 0 in FINISH and IDLE.
REQ-024 START SHALL be ignored outside IDLE; START held high SHALL begin a new transfer the cycle after FINISH.
REQ-025 ABORT=1 in LOAD or SHIFT SHALL cause the next state to be IDLE, with SCLK=0 and CS_N=1, and ABORTED=1 for one cycle; no DONE, and RX_DATA and XFER_CNT unchanged.
REQ-026 ABORT SHALL be ignored in IDLE, CAPTURE and FINISH.
REQ-027 If START and ABORT are both 1 in IDLE, START SHALL win.
REQ-028 The internal half-period counter and bit counter SHALL clear on every SHIFT entry.
REQ-029 DONE and ABORTED SHALL be single-cycle pulses and SHALL never both be 1.
REQ-030 TX_DATA SHALL hold its value until the next accepted START.

Reset
REQ-031 CLR=1 at a CLK edge SHALL force IDLE from any state.
REQ-032 On that edge, outputs SHALL reset to SCLK=0, CS_N=1, WRITE=TE=RE=READ=0, BUSY=DONE=ABORTED=0, and TX_DATA=RX_DATA=XFER_CNT=8'h00.
REQ-033 CLR SHALL take priority over START and ABORT.
REQ-034 CLR asserted mid-transfer SHALL produce no DONE and no ABORTED pulse.

Verification
REQ-035 With HALF_PERIOD=4, START pulse and TX_IN=8'hA5, RX_IN=8'h3C -> WRITE high at cycle 1; 8 SCLK rises at cycles 6,14,...,62; READ at cycle 66; DONE at cycle 67; RX_DATA=8'h3C; XFER_CNT=1; TX_DATA=8'hA5.
REQ-036 ABORT at cycle 20 of the REQ-035 scenario -> cycle 21 is IDLE, CS_N=1, SCLK=0, ABORTED=1; DONE never asserts; XFER_CNT stays 0.
REQ-037 CLR at cycle 30 mid-SHIFT -> next cycle all outputs at reset values and no status pulse; a START afterwards completes normally.
REQ-038 START held high for 3 transfers with HALF_PERIOD=1 -> DONE at cycles 19, 39, 59; XFER_CNT=3; no lost or extra transfer.
REQ-039 Preload XFER_CNT to 255 via 255 transfers, then run one more -> XFER_CNT=0.
REQ-040 START pulsed during SHIFT with a different TX_IN -> ignored; TX_DATA unchanged; exactly one DONE.
